tdm_demux4: RTL
===============

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: N, default 5, sample width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  a sample is present on `in` this cycle.
REQ-005 Port: sync  input  1  marks the sample on `in` as slot 0 of a frame; ignored when in_valid=0.
REQ-006 Port: in  input  N  serialized sample stream.
REQ-007 Port: out00, out01, out02, out03  output  N each  demultiplexed frame, slots 0..3.
REQ-008 Port: out_valid  output  1  one-cycle pulse, new frame on out00..out03.
REQ-009 Port: sync_err  output  1  one-cycle pulse, sync seen mid-frame.
REQ-010 Port: locked  output  1  high while in LOCKED state.

Function
REQ-011 Block is the receive end of a 4:1 time-division mux stream: four consecutive valid samples, starting at a sync-marked sample, form one frame (slot0..slot3).
REQ-012 FSM states: HUNT, LOCKED; reset state HUNT.
REQ-013 HUNT: in_valid=1 without sync discarded; in_valid=1 with sync captures `in` into staging slot 0, slot counter := 1, next state LOCKED.
REQ-014 LOCKED, in_valid=1, sync=0: `in` captured into staging[slot], slot counter increments mod 4.
REQ-015 LOCKED, in_valid=1, sync=1, slot=0: normal frame start, handled as REQ-014.
REQ-016 LOCKED, in_valid=1, sync=1, slot!=0: partial frame dropped, sync_err pulses next cycle, `in` captured into staging slot 0, slot counter := 1, state stays LOCKED.
REQ-017 in_valid=0: no capture, counter and state hold (gaps allowed anywhere in a frame).
REQ-018 On the capture of slot 3: staging slots 0..2 plus the current `in` copied to out00..out03 at the same edge; out_valid=1 for exactly the following cycle.
REQ-019 Latency: out00..out03 and out_valid update on the edge that captures slot 3; visible one cycle after slot-3 sample is presented.
REQ-020 out00..out03 change only on frame completion; held stable between out_valid pulses.
REQ-021 Slot counter is 2 bits and wraps 3 -> 0 with no extra state.
REQ-022 sync_err and out_valid never both high in the same cycle: a sync at slot!=0 never completes a frame.
REQ-023 locked = (state == LOCKED), registered-state-derived, no combinational path from inputs.

Reset
REQ-024 rst=1 asynchronously forces: state HUNT, slot counter 0, staging regs 0, out00..out03 0, out_valid 0, sync_err 0, locked 0.
REQ-025 Reset mid-frame discards partial frame; outputs already presented are cleared to 0.
REQ-026 After rst deasserts, first out_valid requires a fresh sync-marked sample.

Structure
REQ-027 Shared package tdm_pkg holds: state enum {HUNT, LOCKED}, slot typedef (2-bit), constant N_SLOTS = 4.
REQ-028 One sub-module: decoder_2to4, maps slot counter to one-hot staging write enables (gated by in_valid).
REQ-029 Staging and output registers are separate N-bit register banks; no latches.

Verification
REQ-030 Reset, then in_valid=1 with in=1,2,3,4 (sync on 1) over 4 cycles -> out00..03 = 1,2,3,4, out_valid pulses once, locked=1.
REQ-031 In HUNT, drive in=7,8 with sync=0 -> no capture, locked=0; then sync with in=9 -> locked=1 next cycle.
REQ-032 Locked, frame 1,2 then sync with in=5, then 6,7,8 -> sync_err pulse after 5; out00..03 = 5,6,7,8; stale 1,2 never appear.
REQ-033 Frame 10,11,12,13 with in_valid=0 gaps of 2 cycles between samples -> same outputs and single out_valid as gap-free case.
REQ-034 Two back-to-back frames (sync, 1..4, sync, 5..8) -> out_valid pulses twice; outputs hold 1..4 until second pulse, then 5..8.
REQ-035 Assert rst after slot 2 of a frame -> all outputs 0 immediately; subsequent samples without sync ignored.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

  localparam int unsigned N_SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_2to4.sv
// Slot counter to one-hot staging write enables, gated by a global enable.
module decoder_2to4
  import tdm_pkg::*;
(
  input  slot_t              slot_i,
  input  logic               en_i,
  output logic [N_SLOTS-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) begin
      unique case (slot_i)
        2'd0: we_o = 4'b0001;
        2'd1: we_o = 4'b0010;
        2'd2: we_o = 4'b0100;
        default: we_o = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM stream: hunts for a sync-marked sample, then assembles
// four valid samples per frame and presents them on out00..out03 with a valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         sync,
  input  logic [N-1:0] in,
  output logic [N-1:0] out00,
  output logic [N-1:0] out01,
  output logic [N-1:0] out02,
  output logic [N-1:0] out03,
  output logic         out_valid,
  output logic         sync_err,
  output logic         locked
);

  state_t             state_q, state_d;
  slot_t              slot_q, slot_d;
  slot_t              wr_slot;
  logic               cap_en;
  logic               sync_err_d;
  logic [N_SLOTS-1:0] we;
  logic [N-1:0]       stage_q [N_SLOTS-1];
  logic [N-1:0]       out_q   [N_SLOTS];
  logic               out_valid_q;
  logic               sync_err_q;

  // A valid sync always restarts the frame at slot 0, whatever state we are in.
  always_comb begin
    cap_en     = in_valid && ((state_q == LOCKED) || sync);
    wr_slot    = (in_valid && sync) ? 2'd0 : slot_q;
    sync_err_d = in_valid && sync && (state_q == LOCKED) && (slot_q != 2'd0);
    slot_d     = cap_en ? slot_t'(wr_slot + 2'd1) : slot_q;
    state_d    = cap_en ? LOCKED : state_q;
  end

  decoder_2to4 u_decoder (
    .slot_i (wr_slot),
    .en_i   (cap_en),
    .we_o   (we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int unsigned i = 0; i < N_SLOTS - 1; i++) stage_q[i] <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) out_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      out_valid_q <= we[N_SLOTS-1];
      sync_err_q  <= sync_err_d;
      for (int unsigned i = 0; i < N_SLOTS - 1; i++) begin
        if (we[i]) stage_q[i] <= in;
      end
      // Slot 3 is never staged: it goes straight to the output bank with slots 0..2.
      if (we[N_SLOTS-1]) begin
        for (int unsigned i = 0; i < N_SLOTS - 1; i++) out_q[i] <= stage_q[i];
        out_q[N_SLOTS-1] <= in;
      end
    end
  end

  assign out00     = out_q[0];
  assign out01     = out_q[1];
  assign out02     = out_q[2];
  assign out03     = out_q[3];
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == LOCKED);

endmodule
